// File: rtl/svo_stream_timing.sv
`default_nettype none
// ============================================================================
// Module   : svo_stream_timing
// Purpose  : Buffers an AXI-Stream of 24-bit RGB pixels (tuser = start of
//            frame) in a small FIFO and replays it under a fixed raster
//            timing (default 640x480@60). Produces DE, HSYNC, VSYNC and RGB
//            for a TMDS/HDMI encoder. The stream is aligned to the raster
//            by its tuser marker; an empty FIFO during an active pixel
//            raises an underflow pulse and the block resynchronises on the
//            next frame start.
// Ports    : clk             - pixel clock
//            resetn          - synchronous active-low reset
//            in_axis_tvalid  - upstream pixel valid
//            in_axis_tready  - FIFO can accept a pixel (registered)
//            in_axis_tdata   - pixel {R,G,B}
//            in_axis_tuser   - start-of-frame marker
//            out_de          - data enable, high in active area
//            out_hsync       - horizontal sync, active low
//            out_vsync       - vertical sync, active low
//            out_rgb         - pixel data, 0 outside active area
//            underflow       - one-cycle pulse on FIFO empty in active area
//            underflow_count - saturating underflow counter (optional)
// Options  : define SVO_STREAM_UNDERFLOW_CNT_EN to add underflow_count.
// Revision : 1.0 - initial release
// ============================================================================
module svo_stream_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16,
  parameter int BPP        = 24
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_axis_tvalid,
  output logic           in_axis_tready,
  input  logic [BPP-1:0] in_axis_tdata,
  input  logic           in_axis_tuser,
  output logic           out_de,
  output logic           out_hsync,
  output logic           out_vsync,
  output logic [BPP-1:0] out_rgb,
  output logic           underflow
`ifdef SVO_STREAM_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]    underflow_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

  // Raster counters
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  // FIFO of {tuser, tdata}
  logic [BPP:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tready_q, tready_d;

  // Control and registered outputs
  state_t        state_q, state_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [BPP-1:0] rgb_q, rgb_d;
  logic          underflow_q, underflow_d;

  logic          push;
  logic          pop;
  logic          active;
  logic          frame_start;
  logic          fifo_empty;
  logic [BPP:0]  head;
  logic          head_sof;

  always_comb begin
    // Free-running raster, independent of the stream
    hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end

    active      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    de_d        = active;
    hsync_d     = !((hcnt_q >= HS_BEGIN) && (hcnt_q <= HS_END));
    vsync_d     = !((vcnt_q >= VS_BEGIN) && (vcnt_q <= VS_END));

    fifo_empty = (count_q == '0);
    head       = fifo_mem[rd_ptr_q];
    head_sof   = head[BPP];
    // tready_q is the registered "not full" flag, so it alone qualifies a push
    push       = in_axis_tvalid && tready_q;

    pop         = 1'b0;
    state_d     = state_q;
    rgb_d       = '0;
    underflow_d = 1'b0;

    case (state_q)
      SYNC_WAIT: begin
        if (!fifo_empty) begin
          if (!head_sof) begin
            // Leftover pixels of a broken frame: drain one per clock
            pop = 1'b1;
          end else if (frame_start) begin
            // Aligned start of frame doubles as the first active pixel
            pop     = 1'b1;
            rgb_d   = head[BPP-1:0];
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (active) begin
          if (fifo_empty) begin
            underflow_d = 1'b1;
            state_d     = SYNC_WAIT;
          end else if (head_sof && !frame_start) begin
            // Misaligned frame start: leave it at the head for the next
            // raster frame start instead of consuming it here
            state_d = SYNC_WAIT;
          end else begin
            pop   = 1'b1;
            rgb_d = head[BPP-1:0];
          end
        end
      end
      default: state_d = SYNC_WAIT;
    endcase

    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    tready_d = (count_d != FIFO_FULL);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      tready_q    <= 1'b0;
      state_q     <= SYNC_WAIT;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      tready_q    <= tready_d;
      state_q     <= state_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: the pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_axis_tuser, in_axis_tdata};
    end
  end

  assign in_axis_tready = tready_q;
  assign out_de         = de_q;
  assign out_hsync      = hsync_q;
  assign out_vsync      = vsync_q;
  assign out_rgb        = rgb_q;
  assign underflow      = underflow_q;

`ifdef SVO_STREAM_UNDERFLOW_CNT_EN
  logic [15:0] uf_count_q, uf_count_d;

  always_comb begin
    uf_count_d = uf_count_q;
    if (underflow_d && (uf_count_q != 16'hFFFF)) begin
      uf_count_d = uf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      uf_count_q <= '0;
    end else begin
      uf_count_q <= uf_count_d;
    end
  end

  assign underflow_count = uf_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/svo_stream_timing.md
Name: svo_stream_timing

Overview:
- Downstream consumer of the AXI-Stream pixel generators (24-bit RGB, tuser = start-of-frame).
- Buffers incoming pixels in a small FIFO and replays them under a fixed 640x480@60 raster timing: DE, HSYNC, VSYNC and RGB, feeding the TMDS/HDMI encoder.
- Aligns the stream to the raster using tuser.
- Detects underflow and resynchronises on the next frame.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, >=4)
- BPP, 24, bits per pixel

Ports:
- clk  in  1  pixel clock
- resetn  in  1  synchronous active-low reset
- in_axis_tvalid  in  1  upstream pixel valid
- in_axis_tready  out  1  FIFO can accept a pixel
- in_axis_tdata  in  BPP  pixel {R,G,B}
- in_axis_tuser  in  1  start-of-frame marker
- out_de  out  1  data enable, high in active area
- out_hsync  out  1  horizontal sync, active low
- out_vsync  out  1  vertical sync, active low
- out_rgb  out  BPP  pixel data, 0 outside active area
- underflow  out  1  one-cycle pulse on FIFO empty during active pixel

Behaviour:
- Reset is synchronous, active-low: resetn, clock clk.
  - On reset: out_de=0, out_hsync=1, out_vsync=1, out_rgb=0, underflow=0, in_axis_tready=0.
  - FIFO emptied, hcnt=0, vcnt=0, state=SYNC_WAIT.
- Raster counters:
  - hcnt runs 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800); vcnt runs 0..V_TOTAL-1 (= 525).
  - Counters are free-running and advance every clock independent of stream state.
  - hcnt wraps to 0 and increments vcnt; vcnt wraps to 0 after V_TOTAL-1.
- Active area: hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- hsync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- vsync low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- All outputs are registered: 1-cycle latency from counter value to out_de/out_hsync/out_vsync/out_rgb.
- FIFO:
  - Entries are {tuser,tdata}, FIFO_DEPTH deep.
  - in_axis_tready = !full; it is a registered count compare, never depends on tvalid.
  - Push on tvalid&&tready.
  - Push and pop in the same cycle are both honoured, count unchanged.
- State SYNC_WAIT:
  - If FIFO head exists with tuser=0: pop and discard, one per cycle.
  - If head has tuser=1: hold it.
  - When hcnt=0 && vcnt=0 and head is tuser=1: pop it as the first active pixel, enter RUN.
  - out_rgb=0 for all pixels while in SYNC_WAIT; sync/DE timing is unaffected.
- State RUN:
  - Each active-area cycle pops one entry and drives its data on out_rgb (next cycle).
  - No pops outside the active area.
  - Active cycle with FIFO empty: out_rgb=0, underflow pulses for 1 cycle, enter SYNC_WAIT.
  - Popped entry with tuser=1 at any position other than hcnt=0,vcnt=0 (stream misaligned): discard the pixel, drive 0, go to SYNC_WAIT while keeping that entry at head for the next frame start. This means the check is done on the head entry before popping.
- Reset mid-operation drops all FIFO contents and returns to SYNC_WAIT; the upstream must restart its frame.

Optional Feature:
- Macro: SVO_STREAM_UNDERFLOW_CNT_EN.
- Defined: adds output port underflow_count [15:0].
  - Increments on every underflow pulse and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and counter do not exist; underflow pulse behaviour is identical.

Test Plan:
- Reset held 5 cycles, then released -> during reset out_hsync=1, out_vsync=1, out_de=0, out_rgb=0, in_axis_tready=0; tready=1 on the first cycle after release.
- Upstream sends 3 pixels tuser=0, then a full frame starting tuser=1 with pixel value = {x[7:0],y[7:0],8'hA5}, always valid -> junk discarded; first out_de=1 cycle (counters 0,0 plus 1) shows out_rgb=24'h0000A5. Each frame has exactly 640x480 DE cycles with out_rgb matching the pattern.
- Free-running check over 2 frames -> hsync low exactly 96 clocks every 800; vsync low exactly 2 lines (1600 clocks) every 525 lines; DE never overlaps sync.
- Upstream tvalid deasserted for 50 cycles mid-line 10 while in RUN -> single underflow pulse, out_rgb=0 for the rest of the frame, correct output from the next tuser=1 frame onward.
- Upstream always valid during blanking -> FIFO fills to 16, in_axis_tready=0 until active area pops; no pixel lost or duplicated (sequence-number data checked).
- With SVO_STREAM_UNDERFLOW_CNT_EN: three induced underflows -> underflow_count=3; reset -> 0.
